serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer. Computes a WIDTH-bit sum with flags using one 1-bit full-adder cell, iterated LSB-first over WIDTH cycles.
- Serves as the area-minimal alternative to the parallel 16-bit flag adder.
- Provides a start/done handshake with a ready indication toward the issuing control logic.

Parameters:
- WIDTH, 16, operand and result width in bits (minimum 2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- sub  in  1  0 = a+b+cin; 1 = a-b (b inverted internally, carry-in forced to 1, cin ignored).
- a  in  WIDTH  operand A, sampled on the accepting edge.
- b  in  WIDTH  operand B, sampled on the accepting edge.
- cin  in  1  carry-in for add, sampled on the accepting edge.
- ready  out  1  high in IDLE only.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- sum  out  WIDTH  result.
- flag_c  out  1  carry out of MSB (for sub: 1 = no borrow).
- flag_z  out  1  sum == 0.
- flag_n  out  1  sum[WIDTH-1].
- flag_v  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE, bit counter=0, carry register=0, operand shift registers=0.
  - sum=0, all flags=0, done=0, busy=0, ready=1.
  - A partial operation is discarded and no done is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on an edge with start=1, latch a, b^{WIDTH{sub}}, and carry=sub?1:cin; counter=0; go to RUN. With start=0, stay.
  - RUN: each edge processes bit[counter].
    - s = a_bit^b_bit^carry; carry <= cout; s shifts into the result register at the MSB (right shift); counter increments.
    - On the edge processing bit WIDTH-2, also capture that cell's cout as carry-into-MSB.
    - On the edge processing bit WIDTH-1: commit sum and all four flags, go to DONE.
  - DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- Latency:
  - Start accepted at edge E0; done is high in the cycle after edge E_WIDTH.
  - For WIDTH=16, done is high 16 cycles after the accepting edge.
  - Issue interval is WIDTH+2 cycles.
- start while busy or done is high: ignored. No queuing, no effect on the in-flight operation.
- sum and flags are registered. They hold their value from done until the next done or reset; they do not change during RUN. Internal shift state is separate from the sum output register.
- Counter width: clog2(WIDTH). There is no wrap: the counter stops being meaningful outside RUN and is reset on acceptance.
- The datapath is purely the 1-bit cell. No WIDTH-bit adder may be inferred.

Decomposition:
- Shared package add_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - flag index constants FLAG_C=0, FLAG_Z=1, FLAG_N=2, FLAG_V=3 (for packing into a flags bus upstream).
- One sub-module, fa_cell: a 1-bit full adder built from two instances of the team's HA cell plus an OR of the two carries. It is instantiated once, as the combinational per-bit engine.

Test Plan:
- Overflow add: sub=0, a=16'h7FFF, b=16'h0001, cin=0 -> done 16 cycles after accept; sum=16'h8000, C=0, Z=0, N=1, V=1.
- Carry wrap: sub=0, a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, C=1, Z=1, N=0, V=0. Repeat with a=16'h1234, b=16'h0000, cin=1 -> sum=16'h1235, all flags 0.
- Subtract: sub=1, a=16'h0005, b=16'h0005 -> sum=0, C=1, Z=1. Then sub=1, a=16'h0003, b=16'h0005 -> sum=16'hFFFE, C=0, N=1, V=0. Then sub=1, a=16'h8000, b=16'h0001 -> sum=16'h7FFF, V=1, C=1.
- Handshake:
  - Hold start=1 continuously. Operations complete every 18 cycles, and ready is high only in IDLE.
  - Change a/b mid-RUN: the result matches the operands latched at accept.
  - done is exactly 1 cycle wide.
- Reset mid-operation: assert rst asynchronously (between edges) at bit 7 of a running add -> outputs go to reset values immediately, with no done pulse. After release, a fresh add 16'h0002+16'h0003 -> sum=16'h0005.
- Result hold: after done, idle 20 cycles -> sum and flags are unchanged. A new op's RUN phase does not disturb them until its own done.

Source files
------------

// File: rtl/add_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer: FSM states and
// bit positions used when the four result flags are packed into a bus upstream.
package add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

endpackage

// File: rtl/fa_cell.sv
// 1-bit full adder made of two half adders; the carries can never both be set,
// so a plain OR merges them.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s_ab;
  logic c_ab;
  logic c_abc;

  ha_cell u_ha_ab (
    .x (a),
    .y (b),
    .s (s_ab),
    .c (c_ab)
  );

  ha_cell u_ha_abc (
    .x (s_ab),
    .y (ci),
    .s (s),
    .c (c_abc)
  );

  assign co = c_ab | c_abc;

endmodule

// File: rtl/ha_cell.sv
// 1-bit half adder.
module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell walks the operands
// LSB-first, then commits sum and C/Z/N/V flags with a one-cycle done pulse.
module serial_add_ctrl
  import add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_CIN_BIT = CW'(WIDTH - 2);

  state_t state_reg;
  state_t state_next;

  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             cmsb_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-2:0] res_sh_reg;

  logic [WIDTH-1:0] sum_reg;
  logic             flag_c_reg;
  logic             flag_z_reg;
  logic             flag_n_reg;
  logic             flag_v_reg;

  logic [WIDTH-1:0] b_inv;
  logic [WIDTH-1:0] res_full;
  logic             bit_s;
  logic             bit_co;

  // Subtraction is a + ~b + 1, so B is conditionally inverted at accept time.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
      assign b_inv[gi] = b[gi] ^ sub;
    end
  endgenerate

  fa_cell u_fa (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .ci (carry_reg),
    .s  (bit_s),
    .co (bit_co)
  );

  // After WIDTH-1 shifts res_sh_reg holds bits WIDTH-2..0; the current cell
  // output completes the word.
  assign res_full = {bit_s, res_sh_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (cnt_reg == LAST_BIT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_reg)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE:    done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      cmsb_reg   <= 1'b0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      res_sh_reg <= '0;
      sum_reg    <= '0;
      flag_c_reg <= 1'b0;
      flag_z_reg <= 1'b0;
      flag_n_reg <= 1'b0;
      flag_v_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b_inv;
            carry_reg <= sub ? 1'b1 : cin;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
          carry_reg  <= bit_co;
          res_sh_reg <= res_full[WIDTH-1:1];
          cnt_reg    <= cnt_reg + CW'(1);
          if (cnt_reg == MSB_CIN_BIT) begin
            cmsb_reg <= bit_co;
          end
          // Outputs only move here, so they stay stable through later RUN phases.
          if (cnt_reg == LAST_BIT) begin
            sum_reg    <= res_full;
            flag_c_reg <= bit_co;
            flag_z_reg <= ~|res_full;
            flag_n_reg <= bit_s;
            flag_v_reg <= cmsb_reg ^ bit_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum    = sum_reg;
  assign flag_c = flag_c_reg;
  assign flag_z = flag_z_reg;
  assign flag_n = flag_n_reg;
  assign flag_v = flag_v_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised scoreboard bench for serial_add_ctrl: accepts are modelled with
// plain arithmetic and checked by an independent monitor on every done pulse.
module tb_serial_add_ctrl;
  import add_pkg::*;

  localparam int W     = 16;
  localparam int LAT   = W;
  localparam int ISSUE = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         flag_c;
  logic         flag_z;
  logic         flag_n;
  logic         flag_v;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_v (flag_v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic [3:0]   flags;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t held;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   hold_mode   = 0;
  int   last_done   = -1;
  bit   prev_done   = 0;

  // Reference: whole-word arithmetic; V from operand/result sign agreement.
  function automatic exp_t model(input logic s, input logic [W-1:0] x,
                                 input logic [W-1:0] y, input logic ci);
    exp_t         e;
    logic [W-1:0] yy;
    logic [W:0]   t;
    logic         cc;
    yy = s ? ~y : y;
    cc = s ? 1'b1 : ci;
    t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
    e.sum = t[W-1:0];
    e.flags = '0;
    e.flags[FLAG_C] = t[W];
    e.flags[FLAG_Z] = (e.sum == '0);
    e.flags[FLAG_N] = e.sum[W-1];
    e.flags[FLAG_V] = (x[W-1] == yy[W-1]) && (e.sum[W-1] != x[W-1]);
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [3:0] dut_flags();
    logic [3:0] f;
    f = '0;
    f[FLAG_C] = flag_c;
    f[FLAG_Z] = flag_z;
    f[FLAG_N] = flag_n;
    f[FLAG_V] = flag_v;
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Accept monitor: records the expected response for every accepted request.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst && start && ready) begin
        e = model(sub, a, b, cin);
        e.acc = cyc + 1;
        q.push_back(e);
        $display("accept  cyc=%0d sub=%0d a=%h b=%h cin=%0d -> exp sum=%h flags=%b",
                 cyc + 1, sub, a, b, cin, e.sum, e.flags);
      end
    end
  end

  // Output monitor: result checks on done, hold checks on every other cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("state_onehot", 32'($countones({ready, busy, done})), 32'd1);
        if (done) begin
          chk("done_width", 32'(prev_done), 32'd0);
          if (q.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
          end else begin
            e = q.pop_front();
            $display("done    cyc=%0d sum=%h flags=%b (exp %h %b)",
                     cyc, sum, dut_flags(), e.sum, e.flags);
            chk("sum", 32'(sum), 32'(e.sum));
            chk("flags", 32'(dut_flags()), 32'(e.flags));
            chk("latency", 32'(cyc - e.acc), 32'(LAT));
            if (hold_mode && last_done >= 0)
              chk("issue_interval", 32'(cyc - last_done), 32'(ISSUE));
            last_done = cyc;
            held = e;
          end
        end else begin
          chk("hold_sum", 32'(sum), 32'(held.sum));
          chk("hold_flags", 32'(dut_flags()), 32'(held.flags));
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("ready_timeout", 32'(ready), 32'd1);
      return;
    end
    sub   = s;
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Operands move after acceptance; the result must not follow them.
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    held.sum   = '0;
    held.flags = '0;
    held.acc   = 0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    #12;
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_flags", 32'(dut_flags()), 32'd0);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    #10 rst = 1'b0;

    issue(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    issue(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    issue(1'b0, 16'h1234, 16'h0000, 1'b1);
    issue(1'b1, 16'h0005, 16'h0005, 1'b0);
    issue(1'b1, 16'h0003, 16'h0005, 1'b1);
    issue(1'b1, 16'h8000, 16'h0001, 1'b0);
    wait_idle();
    repeat (20) @(negedge clk);

    repeat (30) begin
      issue(1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    // Back-to-back operation with start held high and inputs churning.
    hold_mode = 1'b1;
    last_done = -1;
    @(negedge clk);
    start = 1'b1;
    repeat (4 * ISSUE + 2) begin
      @(negedge clk);
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
    end
    start = 1'b0;
    wait_idle();
    hold_mode = 1'b0;

    // Asynchronous reset partway through an operation.
    issue(1'b0, 16'hA5A5, 16'h1357, 1'b1);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_flags", 32'(dut_flags()), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    q.delete();
    held.sum   = '0;
    held.flags = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (ISSUE) @(negedge clk);
    issue(1'b0, 16'h0002, 16'h0003, 1'b0);
    wait_idle();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
